// File: rtl/freqmeter_irq_servicer.sv
// Wishbone classic initiator that services the freqmeters slave without the CPU.
// It programs the IRQ mask and per-channel reload counts, then waits for inta. On each
// interrupt it reads the pending flags and, for each flagged channel in ascending order,
// reads the master and input counts, presents them on a valid/ready result stream,
// restarts the channel and clears its flag.
// Ports:
//   clk_i, rst_i (async, active-low)      clock and reset
//   cyc_o/stb_o/adr_o/we_o/dat_o          Wishbone request (single accesses only)
//   dat_i/ack_i                           Wishbone response
//   inta_i                                freqmeter interrupt (level)
//   enable_i, mask_i, reload_i            run control; mask/reload latched on start
//   res_valid_o/res_ready_i/res_*_o       result stream (channel, master count, input count)
//   busy_o                                high outside IDLE/WAIT_IRQ
//   timeout_o                             one-cycle pulse when a bus access is abandoned
module freqmeter_irq_servicer #(
  parameter int unsigned INPUTS_COUNT = 24,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    cyc_o,
  output logic                    stb_o,
  output logic [8:0]              adr_o,
  output logic                    we_o,
  output logic [31:0]             dat_o,
  input  logic [31:0]             dat_i,
  input  logic                    ack_i,
  input  logic                    inta_i,
  input  logic                    enable_i,
  input  logic [INPUTS_COUNT-1:0] mask_i,
  input  logic [31:0]             reload_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [4:0]              res_chan_o,
  output logic [31:0]             res_master_o,
  output logic [31:0]             res_input_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StInitMask, StInitRld, StWaitIrq, StRdFlags, StScan,
    StRdMaster, StRdInput, StOutput, StRestart, StClear
  } state_e;

  state_e                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic [8:0]              adr_q, adr_d;
  logic                    we_q, we_d;
  logic [31:0]             dat_q, dat_d;
  logic [TmoW-1:0]         tmo_q, tmo_d;
  logic                    tmo_pulse_q, tmo_pulse_d;
  logic [4:0]              ch_q, ch_d;
  logic [INPUTS_COUNT-1:0] mask_q, mask_d;
  logic [31:0]             reload_q, reload_d;
  logic [INPUTS_COUNT-1:0] pend_q, pend_d;
  logic [INPUTS_COUNT-1:0] flags_q, flags_d;
  logic [4:0]              res_chan_q, res_chan_d;
  logic [31:0]             res_master_q, res_master_d;
  logic [31:0]             res_input_q, res_input_d;

  logic                    done;
  logic                    req;
  logic [8:0]              req_adr;
  logic                    req_we;
  logic [31:0]             req_dat;
  logic [31:0]             mask_ext;
  logic                    unused_dat;

  assign unused_dat = ^dat_i;

  function automatic logic [4:0] lowest(input logic [INPUTS_COUNT-1:0] v);
    lowest = '0;
    for (int i = int'(INPUTS_COUNT) - 1; i >= 0; i--) begin
      if (v[i]) lowest = 5'(i);
    end
  endfunction

  always_comb begin
    mask_ext = '0;
    mask_ext[INPUTS_COUNT-1:0] = mask_q;
  end

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    adr_d        = adr_q;
    we_d         = we_q;
    dat_d        = dat_q;
    tmo_d        = tmo_q;
    tmo_pulse_d  = 1'b0;
    ch_d         = ch_q;
    mask_d       = mask_q;
    reload_d     = reload_q;
    pend_d       = pend_q;
    flags_d      = flags_q;
    res_chan_d   = res_chan_q;
    res_master_d = res_master_q;
    res_input_d  = res_input_q;
    done         = 1'b0;
    req          = 1'b0;
    req_adr      = '0;
    req_we       = 1'b0;
    req_dat      = '0;

    // Bus engine: completion on ack, abandon after TIMEOUT strobe cycles.
    if (cyc_q) begin
      if (ack_i) begin
        done  = 1'b1;
        cyc_d = 1'b0;
        adr_d = '0;
        we_d  = 1'b0;
        dat_d = '0;
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
        cyc_d       = 1'b0;
        adr_d       = '0;
        we_d        = 1'b0;
        dat_d       = '0;
        tmo_d       = '0;
        tmo_pulse_d = 1'b1;
        state_d     = StWaitIrq;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          mask_d   = mask_i;
          reload_d = reload_i;
          state_d  = StInitMask;
        end
      end
      StInitMask: begin
        req = 1'b1; req_adr = 9'h000; req_we = 1'b1; req_dat = mask_ext;
        if (done) begin
          pend_d  = mask_q;
          state_d = StInitRld;
        end
      end
      StInitRld: begin
        if (done) begin
          for (int i = 0; i < int'(INPUTS_COUNT); i++) begin
            if (ch_q == 5'(i)) pend_d[i] = 1'b0;
          end
        end else if (!cyc_q) begin
          if (pend_q == '0) begin
            state_d = StWaitIrq;
          end else begin
            ch_d = lowest(pend_q);
            req = 1'b1; req_adr = {2'b01, lowest(pend_q), 2'b00}; req_we = 1'b1;
            req_dat = reload_q;
          end
        end
      end
      StWaitIrq: begin
        if (!enable_i)   state_d = StIdle;
        else if (inta_i) state_d = StRdFlags;
      end
      StRdFlags: begin
        req = 1'b1; req_adr = 9'h000;
        if (done) begin
          flags_d = dat_i[INPUTS_COUNT-1:0] & mask_q;
          state_d = StScan;
        end
      end
      StScan: begin
        if (flags_q == '0) begin
          state_d = StWaitIrq;
        end else begin
          ch_d    = lowest(flags_q);
          state_d = StRdMaster;
        end
      end
      StRdMaster: begin
        req = 1'b1; req_adr = {2'b10, ch_q, 2'b00};
        if (done) begin
          res_master_d = dat_i;
          state_d      = StRdInput;
        end
      end
      StRdInput: begin
        req = 1'b1; req_adr = {2'b11, ch_q, 2'b00};
        if (done) begin
          res_input_d = dat_i;
          res_chan_d  = ch_q;
          state_d     = StOutput;
        end
      end
      StOutput: begin
        if (res_ready_i) state_d = StRestart;
      end
      StRestart: begin
        req = 1'b1; req_adr = {2'b01, ch_q, 2'b00}; req_we = 1'b1; req_dat = reload_q;
        if (done) state_d = StClear;
      end
      StClear: begin
        req = 1'b1; req_adr = 9'h004; req_we = 1'b1; req_dat = 32'd1 << ch_q;
        if (done) begin
          for (int i = 0; i < int'(INPUTS_COUNT); i++) begin
            if (ch_q == 5'(i)) flags_d[i] = 1'b0;
          end
          state_d = StScan;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new access starts only from a quiet bus, which guarantees the idle gap.
    if (req && !cyc_q) begin
      cyc_d = 1'b1;
      adr_d = req_adr;
      we_d  = req_we;
      dat_d = req_dat;
      tmo_d = '0;
    end

    // Disable takes effect on state changes; a captured result is still delivered.
    if (!enable_i && state_d != state_q && state_d != StOutput && state_d != StIdle) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      cyc_q        <= 1'b0;
      adr_q        <= '0;
      we_q         <= 1'b0;
      dat_q        <= '0;
      tmo_q        <= '0;
      tmo_pulse_q  <= 1'b0;
      ch_q         <= '0;
      mask_q       <= '0;
      reload_q     <= '0;
      pend_q       <= '0;
      flags_q      <= '0;
      res_chan_q   <= '0;
      res_master_q <= '0;
      res_input_q  <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      dat_q        <= dat_d;
      tmo_q        <= tmo_d;
      tmo_pulse_q  <= tmo_pulse_d;
      ch_q         <= ch_d;
      mask_q       <= mask_d;
      reload_q     <= reload_d;
      pend_q       <= pend_d;
      flags_q      <= flags_d;
      res_chan_q   <= res_chan_d;
      res_master_q <= res_master_d;
      res_input_q  <= res_input_d;
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign adr_o        = adr_q;
  assign we_o         = we_q;
  assign dat_o        = dat_q;
  assign timeout_o    = tmo_pulse_q;
  assign res_valid_o  = (state_q == StOutput);
  assign res_chan_o   = res_chan_q;
  assign res_master_o = res_master_q;
  assign res_input_o  = res_input_q;
  assign busy_o       = (state_q != StIdle) && (state_q != StWaitIrq);

endmodule

// File: tb/tb_freqmeter_irq_servicer.sv
// Bench for freqmeter_irq_servicer: a behavioural freqmeter slave answers bus accesses,
// and expected bus accesses and results are queued by the stimulus and checked by the
// negedge monitor as the DUT presents them.
module tb_freqmeter_irq_servicer;
  localparam int unsigned N   = 24;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cyc_o, stb_o, we_o;
  logic [8:0]    adr_o;
  logic [31:0]   dat_o, dat_i;
  logic          ack_i, inta_i, enable_i;
  logic [N-1:0]  mask_i;
  logic [31:0]   reload_i;
  logic          res_valid_o, res_ready_i;
  logic [4:0]    res_chan_o;
  logic [31:0]   res_master_o, res_input_o;
  logic          busy_o, timeout_o;

  always #5 clk = ~clk;

  freqmeter_irq_servicer #(.INPUTS_COUNT(N), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_o(cyc_o), .stb_o(stb_o), .adr_o(adr_o), .we_o(we_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .inta_i(inta_i), .enable_i(enable_i),
    .mask_i(mask_i), .reload_i(reload_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_chan_o(res_chan_o), .res_master_o(res_master_o),
    .res_input_o(res_input_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  typedef struct packed {logic we; logic [8:0] adr; logic [31:0] dat;} bus_t;
  typedef struct packed {logic [4:0] chan; logic [31:0] m; logic [31:0] i;} res_t;

  bus_t        exp_bus[$];
  res_t        exp_res[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sl_flags, sl_mask;
  logic [31:0] sl_master[32];
  logic [31:0] sl_input[32];
  logic        noack_en, noack_all, in_access;
  logic [8:0]  noack_adr;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] sl_read(input logic [8:0] a);
    case (a[8:7])
      2'b00:   sl_read = (a == 9'h000) ? sl_flags : 32'd0;
      2'b10:   sl_read = sl_master[a[6:2]];
      2'b11:   sl_read = sl_input[a[6:2]];
      default: sl_read = 32'd0;
    endcase
  endfunction

  // Slave model and monitor.
  always @(negedge clk) begin
    bus_t b;
    res_t r;
    if (!rst_i) begin
      ack_i     = 1'b0;
      dat_i     = 32'd0;
      in_access = 1'b0;
    end else begin
      if (res_valid_o && res_ready_i) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected result: chan %0d", res_chan_o);
        end else begin
          r = exp_res.pop_front();
          chk("result", 128'({res_chan_o, res_master_o, res_input_o}), 128'(r));
        end
      end
      if (cyc_o && stb_o) begin
        if (!in_access) begin
          in_access = 1'b1;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected access: we=%0d adr=%0h", we_o, adr_o);
          end else begin
            b = exp_bus.pop_front();
            chk("bus we/adr", 128'({we_o, adr_o}), 128'({b.we, b.adr}));
            if (b.we) chk("bus wdata", 128'(dat_o), 128'(b.dat));
          end
          if (!(noack_all || (noack_en && adr_o == noack_adr))) begin
            ack_i = 1'b1;
            dat_i = sl_read(adr_o);
            if (we_o && adr_o == 9'h000) sl_mask = dat_o;
            if (we_o && adr_o == 9'h004) sl_flags = sl_flags & ~dat_o;
          end
        end else begin
          ack_i = 1'b0;
        end
      end else begin
        ack_i     = 1'b0;
        in_access = 1'b0;
      end
      inta_i = |(sl_flags & sl_mask);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_w(input logic [8:0] a, input logic [31:0] d);
    exp_bus.push_back('{we: 1'b1, adr: a, dat: d});
  endtask

  task automatic push_r(input logic [8:0] a);
    exp_bus.push_back('{we: 1'b0, adr: a, dat: 32'd0});
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_bus.size() != 0 || exp_res.size() != 0 || busy_o || cyc_o) && k < 3000) begin
      step(1);
      k++;
    end
    checks++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL %s: not finished, %0d accesses and %0d results outstanding, required 0",
               name, exp_bus.size(), exp_res.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b0; enable_i = 1'b0; mask_i = '0; reload_i = '0; res_ready_i = 1'b1;
    ack_i = 1'b0; dat_i = '0; inta_i = 1'b0; in_access = 1'b0;
    noack_en = 1'b0; noack_all = 1'b0; noack_adr = '0;
    sl_flags = '0; sl_mask = '0;
    for (int i = 0; i < 32; i++) begin
      sl_master[i] = '0;
      sl_input[i]  = '0;
    end
    step(3);
    chk("reset outputs", 128'({cyc_o, stb_o, adr_o, we_o, dat_o, res_valid_o, busy_o, timeout_o,
                               res_chan_o, res_master_o, res_input_o}), 128'(0));
    rst_i = 1'b1;
    step(3);
    chk("idle disabled busy/cyc", 128'({busy_o, cyc_o}), 128'(0));

    // 1: initialisation with two channels.
    mask_i = 24'h000003; reload_i = 32'd2;
    push_w(9'h000, 32'd3); push_w(9'h080, 32'd2); push_w(9'h084, 32'd2);
    enable_i = 1'b1;
    step(2);
    chk("init busy", 128'(busy_o), 128'(1));
    wait_done("init");
    chk("after init busy", 128'(busy_o), 128'(0));

    // 2: one flagged channel.
    sl_master[0] = 32'd1000; sl_input[0] = 32'd37;
    push_r(9'h000); push_r(9'h100); push_r(9'h180); push_w(9'h080, 32'd2); push_w(9'h004, 32'd1);
    exp_res.push_back('{chan: 5'd0, m: 32'd1000, i: 32'd37});
    sl_flags = 32'h1;
    wait_done("single channel");
    chk("inta low after clear", 128'(inta_i), 128'(0));

    // 3: full mask, two flags serviced lowest first.
    enable_i = 1'b0;
    step(4);
    chk("disabled busy", 128'(busy_o), 128'(0));
    mask_i = 24'hFFFFFF;
    push_w(9'h000, 32'h00FFFFFF);
    for (int i = 0; i < 24; i++) push_w(9'(9'h080 + 4 * i), 32'd2);
    enable_i = 1'b1;
    wait_done("reinit full mask");
    sl_master[12] = 32'd500; sl_input[12] = 32'd77;
    push_r(9'h000); push_r(9'h100); push_r(9'h180); push_w(9'h080, 32'd2); push_w(9'h004, 32'd1);
    push_r(9'h130); push_r(9'h1B0); push_w(9'h0B0, 32'd2); push_w(9'h004, 32'h1000);
    exp_res.push_back('{chan: 5'd0, m: 32'd1000, i: 32'd37});
    exp_res.push_back('{chan: 5'd12, m: 32'd500, i: 32'd77});
    sl_flags = 32'h001001;
    wait_done("two channels");

    // 4: result stalled by res_ready_i low.
    res_ready_i = 1'b0;
    sl_master[2] = 32'hDEAD0002; sl_input[2] = 32'h22;
    push_r(9'h000); push_r(9'h108); push_r(9'h188); push_w(9'h088, 32'd2); push_w(9'h004, 32'd4);
    exp_res.push_back('{chan: 5'd2, m: 32'hDEAD0002, i: 32'h22});
    sl_flags = 32'h4;
    n = 0;
    while (!res_valid_o && n < 200) begin
      step(1);
      n++;
    end
    chk("stall valid seen", 128'(res_valid_o), 128'(1));
    for (int i = 0; i < 20; i++) begin
      chk("stall fields/cyc", 128'({res_valid_o, cyc_o, res_chan_o, res_master_o, res_input_o}),
          128'({1'b1, 1'b0, 5'd2, 32'hDEAD0002, 32'h22}));
      step(1);
    end
    res_ready_i = 1'b1;
    step(1);
    chk("accepted valid low", 128'(res_valid_o), 128'(0));
    wait_done("stalled channel");

    // 5: master read never acked, then serviced on the re-read.
    sl_master[5] = 32'h5555; sl_input[5] = 32'h55;
    noack_en = 1'b1; noack_adr = 9'h114;
    push_r(9'h000); push_r(9'h114);
    push_r(9'h000); push_r(9'h114); push_r(9'h194); push_w(9'h094, 32'd2); push_w(9'h004, 32'h20);
    exp_res.push_back('{chan: 5'd5, m: 32'h5555, i: 32'h55});
    sl_flags = 32'h20;
    n = 0;
    while (!(stb_o && adr_o == 9'h114) && n < 200) begin
      step(1);
      n++;
    end
    n = 0;
    while (stb_o && n < 100) begin
      n++;
      step(1);
    end
    chk("timeout strobe cycles", 128'(n), 128'(TMO));
    chk("timeout pulse", 128'({timeout_o, busy_o, res_valid_o}), 128'({1'b1, 1'b0, 1'b0}));
    noack_en = 1'b0;
    step(1);
    chk("timeout pulse width", 128'(timeout_o), 128'(0));
    wait_done("timeout recovery");

    // 6: reset while a strobe is outstanding.
    noack_all = 1'b1;
    push_r(9'h000);
    sl_flags = 32'h40;
    n = 0;
    while (!(stb_o && in_access) && n < 200) begin
      step(1);
      n++;
    end
    chk("reset test strobe", 128'(stb_o), 128'(1));
    rst_i = 1'b0;
    #1;
    chk("async reset outputs", 128'({cyc_o, stb_o, adr_o, we_o, dat_o, res_valid_o, busy_o,
                                     timeout_o}), 128'(0));
    noack_all = 1'b0;
    sl_flags = '0;
    mask_i = 24'h000003; reload_i = 32'd5;
    step(3);
    chk("queue empty before reinit", 128'(exp_bus.size()), 128'(0));
    push_w(9'h000, 32'd3); push_w(9'h080, 32'd5); push_w(9'h084, 32'd5);
    rst_i = 1'b1;
    step(1);
    wait_done("reinit after reset");
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
